// File: rtl/fetch_stage_pkg.sv
// Uop package: the fetch-to-decode uop format and front-end constants.
// When FETCH_MISALIGN_EXC_EN is defined, fetch_t carries an 'ex' flag that
// marks a misaligned-redirect exception uop.
package Uop;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] enc;
`ifdef FETCH_MISALIGN_EXC_EN
    logic        ex;
`endif
  } fetch_t;

  // Clears the byte-offset bits so the address points at an instruction word.
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & ~32'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/pipeline_if.sv
// Valid/stall handshake between pipeline stages. The producer drives valid
// and the consumer drives stall. A transfer happens on a clock edge where
// valid is high and stall is low.
interface pipeline_if;
  logic valid;
  logic stall;

  modport Downstream (output valid, input stall);
  modport Upstream   (input valid, output stall);
endinterface

// File: rtl/fetch_stage_buffer.sv
// fetch_buffer: 2-entry synchronous FIFO of fetch_t with push, pop, flush and
// an occupancy count. Flush has priority over push, so a response that arrives
// in a redirect cycle never lands in the cleared buffer.
module fetch_buffer
  import Uop::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  fetch_t     pushData,
  input  logic       pop,
  output fetch_t     headData,
  output logic [1:0] count
);

  fetch_t entries [2];
  logic   rdPtr;
  logic   wrPtr;

  assign headData = entries[rdPtr];

  // Pointer and count bookkeeping; a flush returns the buffer to empty at once.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        wrPtr <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage write. It is not reset because the count already marks the entries as empty.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      entries[wrPtr] <= pushData;
    end
  end

  // The fetch credit scheme must never push into a full buffer.
  assert property (@(posedge clk) disable iff (rst) !(push && !flush && count == 2'd2));

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order instruction-memory reads with up
// to MAX_OUTSTANDING credits (reads in flight plus buffered responses), tags
// each response with its request PC, and presents a registered uop to decode.
// A redirect flushes buffered work and drops the stale responses still in flight.
// The optional macro FETCH_MISALIGN_EXC_EN turns a misaligned redirect into a
// single exception uop. Without it, the target is word-aligned.
module fetch_stage
  import Uop::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst,
  pipeline_if.Downstream     d,
  output fetch_t             uopOut,
  output logic               imemReqValid,
  output logic [31:0]        imemReqAddr,
  input  logic               imemReqReady,
  input  logic               imemRspValid,
  input  logic [31:0]        imemRspData,
  input  logic               redirectValid,
  input  logic [31:0]        redirectPc
);

  localparam logic [2:0] CREDIT_LIMIT = 3'(MAX_OUTSTANDING);

  logic [31:0] pc;
  logic [1:0]  inflight;
  logic [1:0]  dropCnt;
  logic [1:0]  fifoCount;
  logic [31:0] reqPcQ [2];
  logic        qRd;
  logic        qWr;
  logic        dValid;
  fetch_t      uopReg;
  fetch_t      fifoHead;
  fetch_t      rspUop;
  logic [31:0] redirectTarget;
  logic        accept;
  logic        rspTagged;
  logic        rspLive;
  logic        advance;
  logic        fifoPush;
  logic        fifoPop;
  logic        creditOk;
  logic        fetchIdle;

`ifdef FETCH_MISALIGN_EXC_EN
  logic   excPending;
  logic   excIdle;
  logic   misaligned;
  fetch_t excUop;
  assign misaligned     = redirectPc[1:0] != 2'b00;
  assign redirectTarget = redirectPc;
  assign fetchIdle      = excIdle;
`else
  assign redirectTarget = wordAlign(redirectPc);
  assign fetchIdle      = 1'b0;
`endif

  assign creditOk     = ({1'b0, inflight} + {1'b0, fifoCount}) < CREDIT_LIMIT;
  assign imemReqValid = !rst && !redirectValid && !fetchIdle && creditOk;
  assign imemReqAddr  = pc;
  assign accept       = imemReqValid && imemReqReady;
  assign rspTagged    = imemRspValid && (dropCnt == 2'd0);
  assign rspLive      = rspTagged && !redirectValid;
  assign advance      = !dValid || !d.stall;
  assign fifoPop      = !redirectValid && advance && (fifoCount != 2'd0);
  assign fifoPush     = rspLive && !(advance && (fifoCount == 2'd0));
  assign d.valid      = dValid;
  assign uopOut       = uopReg;

  // Build the tagged response uop, and the exception uop when that feature is enabled.
  always_comb begin
    rspUop     = '0;
    rspUop.pc  = reqPcQ[qRd];
    rspUop.enc = imemRspData;
`ifdef FETCH_MISALIGN_EXC_EN
    excUop     = '0;
    excUop.pc  = pc;
    excUop.ex  = 1'b1;
`endif
  end

  // Program counter: reset vector, redirect target, or next word after an accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirectValid) begin
      pc <= redirectTarget;
    end else if (accept) begin
      pc <= pc + 32'(INSTR_BYTES);
    end
  end

  // Count reads in flight, and on a redirect mark the ones still owed as stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 2'd0;
      dropCnt  <= 2'd0;
    end else begin
      inflight <= inflight + {1'b0, accept} - {1'b0, imemRspValid};
      if (redirectValid) begin
        dropCnt <= inflight - {1'b0, imemRspValid};
      end else if (imemRspValid && dropCnt != 2'd0) begin
        dropCnt <= dropCnt - 2'd1;
      end
    end
  end

  // Request-PC queue: pushed on accept, popped by each response that is not dropped.
  always_ff @(posedge clk) begin
    if (rst || redirectValid) begin
      qRd <= 1'b0;
      qWr <= 1'b0;
    end else begin
      if (accept) begin
        reqPcQ[qWr] <= pc;
        qWr         <= ~qWr;
      end
      if (rspTagged) begin
        qRd <= ~qRd;
      end
    end
  end

`ifdef FETCH_MISALIGN_EXC_EN
  // A misaligned redirect arms one exception uop and parks fetch until the next redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      excPending <= 1'b0;
      excIdle    <= 1'b0;
    end else if (redirectValid) begin
      excPending <= misaligned;
      excIdle    <= misaligned;
    end else if (excPending && advance) begin
      excPending <= 1'b0;
    end
  end
`endif

  // Output register. Buffered uops go first, then a bypassed response; it holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      dValid <= 1'b0;
      uopReg <= '0;
    end else if (redirectValid) begin
      dValid <= 1'b0;
    end else if (advance) begin
      if (fifoCount != 2'd0) begin
        dValid <= 1'b1;
        uopReg <= fifoHead;
      end else if (rspLive) begin
        dValid <= 1'b1;
        uopReg <= rspUop;
`ifdef FETCH_MISALIGN_EXC_EN
      end else if (excPending) begin
        dValid <= 1'b1;
        uopReg <= excUop;
`endif
      end else begin
        dValid <= 1'b0;
      end
    end
  end

  fetch_buffer u_buffer (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirectValid),
    .push     (fifoPush),
    .pushData (rspUop),
    .pop      (fifoPop),
    .headData (fifoHead),
    .count    (fifoCount)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized bench for fetch_stage. The memory
// returns a fixed word per address after a per-request latency, in order. The
// reference model expects uops to run in ascending order, 4 bytes apart, from
// the most recent reset or redirect target, each carrying that address's word.
module tb_fetch_stage;
  import Uop::*;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  logic        clk = 1'b0;
  logic        rst;
  fetch_t      uopOut;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        redirectValid;
  logic [31:0] redirectPc;

  pipeline_if pif ();

  fetch_stage #(.RESET_PC(32'h0000_0100), .MAX_OUTSTANDING(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .d             (pif),
    .uopOut        (uopOut),
    .imemReqValid  (imemReqValid),
    .imemReqAddr   (imemReqAddr),
    .imemReqReady  (imemReqReady),
    .imemRspValid  (imemRspValid),
    .imemRspData   (imemRspData),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc)
  );

  always #5 clk = ~clk;

  memReq_t     memQ [$];
  int          cycle = 0;
  int          lastDue = 0;
  int          latency = 1;
  int          testsRun = 0;
  int          testsFailed = 0;
  int          xferCount = 0;
  bit          modelOn = 1'b0;
  logic [31:0] expPc;
  bit          prevHeld = 1'b0;
  fetch_t      prevUop;
  logic        obsValid;
  fetch_t      obsUop;
  logic        obsReqValid;
  logic [31:0] obsReqAddr;
  bit          lastXfer;
  logic [31:0] lastXferPc;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive the memory response, sample the DUT, run the model, then clock.
  task automatic applyStimulus();
    bit accept;
    int due;
    due = 0;
    if (!rst && memQ.size() > 0 && memQ[0].due <= cycle) begin
      imemRspValid = 1'b1;
      imemRspData  = memWord(memQ[0].addr);
    end else begin
      imemRspValid = 1'b0;
      imemRspData  = 32'h0;
    end
    #1;
    obsValid    = pif.valid;
    obsUop      = uopOut;
    obsReqValid = imemReqValid;
    obsReqAddr  = imemReqAddr;
    accept      = obsReqValid && imemReqReady;

    if (prevHeld) begin
      checkBit("holdValid", obsValid, 1'b1);
      checkOutput("holdPc", obsUop.pc, prevUop.pc);
      checkOutput("holdEnc", obsUop.enc, prevUop.enc);
    end
    prevHeld   = obsValid && pif.stall && !redirectValid && !rst;
    prevUop    = obsUop;
    lastXfer   = obsValid && !pif.stall && !redirectValid && !rst;
    lastXferPc = obsUop.pc;

    if (modelOn && lastXfer) begin
      checkOutput("xferPc", obsUop.pc, expPc);
      checkOutput("xferEnc", obsUop.enc, memWord(expPc));
`ifdef FETCH_MISALIGN_EXC_EN
      checkBit("xferEx", obsUop.ex, 1'b0);
`endif
      expPc = expPc + 32'd4;
      xferCount++;
    end

    if (accept) begin
      due = cycle + latency;
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
    end

    @(posedge clk);
    if (imemRspValid) void'(memQ.pop_front());
    if (accept) begin
      memQ.push_back('{obsReqAddr, due});
      checkOutput("outstanding", (memQ.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
    end
    if (rst) begin
      memQ.delete();
      lastDue = cycle;
    end
    cycle++;
    @(negedge clk);
  endtask

  // Run until a uop transfers or the budget runs out, then check its PC.
  task automatic waitXfer(input string tag, input int budget, input logic [31:0] pcExp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      applyStimulus();
      if (lastXfer) seen = 1'b1;
    end
    checkOutput(tag, seen ? lastXferPc : 32'hDEAD_DEAD, pcExp);
  endtask

  initial begin
    int  startXfers;
    bit  doRedir;
    bit  found;

    rst           = 1'b1;
    pif.stall     = 1'b0;
    imemReqReady  = 1'b1;
    imemRspValid  = 1'b0;
    imemRspData   = 32'h0;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    applyStimulus();
    checkBit("resetReqValid", obsReqValid, 1'b0);
    checkBit("resetValid", obsValid, 1'b0);
    checkOutput("resetUopPc", obsUop.pc, 32'h0);
    checkOutput("resetUopEnc", obsUop.enc, 32'h0);

    // First fetch after reset, L=1, no stall
    rst     = 1'b0;
    modelOn = 1'b1;
    expPc   = 32'h100;
    applyStimulus();
    checkBit("reqAfterReset", obsReqValid, 1'b1);
    checkOutput("reqAddrAfterReset", obsReqAddr, 32'h100);
    checkBit("validC0", obsValid, 1'b0);
    applyStimulus();
    checkBit("validC1", obsValid, 1'b0);
    applyStimulus();
    checkBit("validC2", obsValid, 1'b1);
    checkOutput("pcC2", obsUop.pc, 32'h100);

    // Three stalled cycles while 0x104 is presented
    pif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkBit("stallValid", obsValid, 1'b1);
      checkOutput("stallPc", obsUop.pc, 32'h104);
    end
    pif.stall = 1'b0;
    applyStimulus();
    checkOutput("releasePc", obsUop.pc, 32'h104);
    applyStimulus();
    checkBit("afterStallValid0", obsValid, 1'b1);
    checkOutput("afterStallPc0", obsUop.pc, 32'h108);
    applyStimulus();
    checkBit("afterStallValid1", obsValid, 1'b1);
    checkOutput("afterStallPc1", obsUop.pc, 32'h10C);

    // Backpressure with latency 3
    latency = 3;
    for (int i = 0; i < 60; i++) begin
      imemReqReady = ($urandom_range(0, 1) == 1);
      applyStimulus();
    end
    imemReqReady = 1'b1;

    // Redirect with two reads in flight
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (memQ.size() == 2) found = 1'b1;
      else applyStimulus();
    end
    checkBit("twoInflight", found, 1'b1);
    redirectValid = 1'b1;
    redirectPc    = 32'h2000;
    applyStimulus();
    checkBit("reqDuringRedirect", obsReqValid, 1'b0);
    redirectValid = 1'b0;
    expPc         = 32'h2000;
    applyStimulus();
    checkBit("validAfterRedirect", obsValid, 1'b0);
    waitXfer("inflightRedirectPc", 30, 32'h2000);

    // Redirect timing with L=1
    latency = 1;
    for (int i = 0; i < 8; i++) applyStimulus();
    redirectValid = 1'b1;
    redirectPc    = 32'h3000;
    applyStimulus();
    checkBit("reqInRedirectCycle", obsReqValid, 1'b0);
    redirectValid = 1'b0;
    expPc         = 32'h3000;
    applyStimulus();
    checkBit("validR1", obsValid, 1'b0);
    checkBit("reqR1", obsReqValid, 1'b1);
    checkOutput("reqAddrR1", obsReqAddr, 32'h3000);
    applyStimulus();
    checkBit("validR2", obsValid, 1'b0);
    applyStimulus();
    checkBit("validR3", obsValid, 1'b1);
    checkOutput("pcR3", obsUop.pc, 32'h3000);

    // Redirect while stalled
    pif.stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus();
      if (obsValid) found = 1'b1;
    end
    checkBit("validBeforeStallRedirect", found, 1'b1);
    redirectValid = 1'b1;
    redirectPc    = 32'h4000;
    applyStimulus();
    redirectValid = 1'b0;
    expPc         = 32'h4000;
    applyStimulus();
    checkBit("validAfterStallRedirect", obsValid, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus();
    pif.stall = 1'b0;
    waitXfer("stallRedirectPc", 10, 32'h4000);

    // Misaligned redirect
    for (int i = 0; i < 6; i++) applyStimulus();
    redirectValid = 1'b1;
    redirectPc    = 32'h2002;
`ifdef FETCH_MISALIGN_EXC_EN
    modelOn = 1'b0;
    applyStimulus();
    checkBit("misReqR0", obsReqValid, 1'b0);
    redirectValid = 1'b0;
    applyStimulus();
    checkBit("misReqR1", obsReqValid, 1'b0);
    checkBit("misValidR1", obsValid, 1'b0);
    applyStimulus();
    checkBit("misValidR2", obsValid, 1'b1);
    checkOutput("misPc", obsUop.pc, 32'h2002);
    checkOutput("misEnc", obsUop.enc, 32'h0);
    checkBit("misEx", obsUop.ex, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkBit("misIdleReq", obsReqValid, 1'b0);
      checkBit("misIdleValid", obsValid, 1'b0);
    end
`else
    applyStimulus();
    checkBit("misReqR0", obsReqValid, 1'b0);
    redirectValid = 1'b0;
    expPc         = 32'h2000;
    applyStimulus();
    checkBit("alignReqR1", obsReqValid, 1'b1);
    checkOutput("alignReqAddr", obsReqAddr, 32'h2000);
    waitXfer("alignPc", 10, 32'h2000);
`endif
    redirectValid = 1'b1;
    redirectPc    = 32'h5000;
    applyStimulus();
    redirectValid = 1'b0;
    modelOn       = 1'b1;
    expPc         = 32'h5000;
    waitXfer("resumePc", 10, 32'h5000);

    // PC wrap at the top of the address space
    redirectValid = 1'b1;
    redirectPc    = 32'hFFFF_FFF8;
    applyStimulus();
    redirectValid = 1'b0;
    expPc         = 32'hFFFF_FFF8;
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("wrapExpPc", (expPc < 32'h100) ? 32'd1 : 32'd0, 32'd1);

    // Randomized traffic
    startXfers = xferCount;
    for (int i = 0; i < 300; i++) begin
      latency      = $urandom_range(1, 4);
      imemReqReady = ($urandom_range(0, 3) != 0);
      pif.stall    = ($urandom_range(0, 9) < 3);
      doRedir      = ($urandom_range(0, 39) == 0);
      if (doRedir) begin
        redirectValid = 1'b1;
        redirectPc    = 32'h8000 + (32'($urandom_range(0, 63)) << 2);
      end
      applyStimulus();
      if (doRedir) begin
        expPc         = redirectPc;
        redirectValid = 1'b0;
      end
    end
    checkBit("randomProgress", (xferCount - startXfers) > 20, 1'b1);

    // Reset in the middle of operation
    rst          = 1'b1;
    pif.stall    = 1'b0;
    imemReqReady = 1'b1;
    latency      = 1;
    applyStimulus();
    checkBit("midResetReq", obsReqValid, 1'b0);
    applyStimulus();
    checkBit("midResetValid", obsValid, 1'b0);
    checkOutput("midResetUopPc", obsUop.pc, 32'h0);
    rst   = 1'b0;
    expPc = 32'h100;
    waitXfer("afterMidResetPc", 10, 32'h100);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
